// File: rtl/gobang_pkg.sv
// Shared types and constants for the five-in-a-row rule engine:
// FSM states, winner codes and the four scan axes.
package gobang_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_BLACK = 2'b01;
    localparam logic [1:0] WIN_WHITE = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    // Axis order: (0,+1), (+1,0), (+1,+1), (+1,-1) as (row step, col step).
    function automatic logic signed [1:0] axis_dr(input logic [1:0] axis);
        if (axis == 2'd0) return 2'sd0;
        return 2'sd1;
    endfunction

    function automatic logic signed [1:0] axis_dc(input logic [1:0] axis);
        case (axis)
            2'd0:    return 2'sd1;
            2'd1:    return 2'sd0;
            2'd2:    return 2'sd1;
            default: return 2'sb11;
        endcase
    endfunction

endpackage

// File: rtl/gobang_win_scan.sv
// Walks eight rays around the latched stone, one cell per cycle, and
// reports whether any axis holds a line of at least WIN_LEN stones.
module gobang_win_scan
    import gobang_pkg::*;
#(
    parameter int BOARD_N = 15,
    parameter int WIN_LEN = 5,
    localparam int CW = $clog2(BOARD_N),
    localparam int NN = BOARD_N * BOARD_N
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_clear,
    input  logic [CW-1:0] i_row,
    input  logic [CW-1:0] i_col,
    input  logic [NN-1:0] i_bitmap,
    output logic          o_done,
    output logic          o_win
);

    localparam logic [4:0]        STEP_LAST = 5'(WIN_LEN - 1);
    localparam logic [5:0]        CNT_WIN   = 6'(WIN_LEN - 1);
    localparam logic signed [7:0] N_S       = 8'(BOARD_N);
    localparam logic [7:0]        N_U       = 8'(BOARD_N);

    logic       r_active;
    logic [1:0] r_axis;
    logic       r_back;
    logic [4:0] r_step;
    logic       r_run;
    logic [5:0] r_cnt;
    logic       r_win;

    logic signed [1:0] w_dr;
    logic signed [1:0] w_dc;
    logic signed [7:0] w_off;
    logic signed [7:0] w_row_s;
    logic signed [7:0] w_col_s;
    logic [7:0]        w_row_u;
    logic [7:0]        w_col_u;
    logic [7:0]        w_idx;
    logic              w_in_board;
    logic [NN-1:0]     w_shifted;
    logic              w_hit;
    logic              w_last;
    logic [5:0]        w_cnt_next;
    logic              w_axis_win;

    always_comb begin
        w_dr    = axis_dr(r_axis);
        w_dc    = axis_dc(r_axis);
        w_off   = r_back ? -$signed({3'b000, r_step}) : $signed({3'b000, r_step});
        w_row_s = $signed({{(8-CW){1'b0}}, i_row});
        w_col_s = $signed({{(8-CW){1'b0}}, i_col});
        if (w_dr == 2'sd1) begin
            w_row_s = w_row_s + w_off;
        end
        if (w_dc == 2'sd1) begin
            w_col_s = w_col_s + w_off;
        end else if (w_dc == 2'sb11) begin
            w_col_s = w_col_s - w_off;
        end
        // Signed bounds keep a ray from sliding onto the neighbouring row.
        w_in_board = (w_row_s >= 8'sd0) && (w_row_s < N_S) &&
                     (w_col_s >= 8'sd0) && (w_col_s < N_S);
        w_row_u    = w_row_s;
        w_col_u    = w_col_s;
        w_idx      = w_row_u * N_U + w_col_u;
        w_shifted  = i_bitmap >> w_idx;
        w_hit      = r_active && r_run && w_in_board && w_shifted[0];
        w_last     = (r_step == STEP_LAST);
        w_cnt_next = r_cnt + {5'd0, w_hit};
        w_axis_win = r_active && r_back && w_last && (w_cnt_next >= CNT_WIN);
    end

    assign o_done = r_active && r_back && w_last && (r_axis == 2'd3);
    assign o_win  = r_win || w_axis_win;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_axis   <= 2'd0;
            r_back   <= 1'b0;
            r_step   <= 5'd1;
            r_run    <= 1'b0;
            r_cnt    <= 6'd0;
            r_win    <= 1'b0;
        end else if (i_clear) begin
            r_active <= 1'b0;
            r_win    <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_axis   <= 2'd0;
            r_back   <= 1'b0;
            r_step   <= 5'd1;
            r_run    <= 1'b1;
            r_cnt    <= 6'd0;
            r_win    <= 1'b0;
        end else if (r_active) begin
            if (!w_last) begin
                r_step <= r_step + 5'd1;
                r_run  <= w_hit;
                r_cnt  <= w_cnt_next;
            end else if (!r_back) begin
                r_back <= 1'b1;
                r_step <= 5'd1;
                r_run  <= 1'b1;
                r_cnt  <= w_cnt_next;
            end else begin
                r_win  <= r_win || w_axis_win;
                r_back <= 1'b0;
                r_step <= 5'd1;
                r_run  <= 1'b1;
                r_cnt  <= 6'd0;
                r_axis <= r_axis + 2'd1;
                if (r_axis == 2'd3) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/gobang_game_ctrl.sv
// Game-rule engine: cursor, stone bitmaps, side to move and result,
// with the win test delegated to gobang_win_scan.
module gobang_game_ctrl
    import gobang_pkg::*;
#(
    parameter int BOARD_N  = 15,
    parameter int WIN_LEN  = 5,
    parameter int CUR_WRAP = 0,
    localparam int CW  = $clog2(BOARD_N),
    localparam int MCW = $clog2(BOARD_N * BOARD_N + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_up,
    input  logic                         key_down,
    input  logic                         key_left,
    input  logic                         key_right,
    input  logic                         key_ok,
    input  logic                         key_switch,
    output logic [BOARD_N*BOARD_N-1:0]   display_black,
    output logic [BOARD_N*BOARD_N-1:0]   display_white,
    output logic [CW-1:0]                choose_row,
    output logic [CW-1:0]                choose_col,
    output logic                         turn,
    output logic                         busy,
    output logic                         game_over,
    output logic [1:0]                   winner,
    output logic [MCW-1:0]               move_count
);

    localparam int             NN     = BOARD_N * BOARD_N;
    localparam logic [CW-1:0]  CENTER = CW'(BOARD_N / 2);
    localparam logic [CW-1:0]  EDGE   = CW'(BOARD_N - 1);
    localparam logic [MCW-1:0] FULL   = MCW'(NN);
    localparam logic [7:0]     N_U    = 8'(BOARD_N);

    state_t         r_state,     w_state_nx;
    logic [NN-1:0]  r_black,     w_black_nx;
    logic [NN-1:0]  r_white,     w_white_nx;
    logic [CW-1:0]  r_row,       w_row_nx;
    logic [CW-1:0]  r_col,       w_col_nx;
    logic [CW-1:0]  r_place_row, w_place_row_nx;
    logic [CW-1:0]  r_place_col, w_place_col_nx;
    logic           r_turn,      w_turn_nx;
    logic           r_busy;
    logic           r_game_over;
    logic [1:0]     r_winner,    w_winner_nx;
    logic [MCW-1:0] r_count,     w_count_nx;

    logic [7:0]     w_cur_idx;
    logic [NN-1:0]  w_cur_onehot;
    logic           w_occupied;
    logic [NN-1:0]  w_mover_map;
    logic           w_scan_start;
    logic           w_scan_clear;
    logic           w_scan_done;
    logic           w_scan_win;

    function automatic logic [CW-1:0] cur_dec(input logic [CW-1:0] v);
        if (v == '0) return (CUR_WRAP != 0) ? EDGE : '0;
        return v - 1'b1;
    endfunction

    function automatic logic [CW-1:0] cur_inc(input logic [CW-1:0] v);
        if (v == EDGE) return (CUR_WRAP != 0) ? '0 : EDGE;
        return v + 1'b1;
    endfunction

    assign w_cur_idx    = 8'(r_row) * N_U + 8'(r_col);
    assign w_cur_onehot = {{(NN-1){1'b0}}, 1'b1} << w_cur_idx;
    assign w_occupied   = |((r_black | r_white) & w_cur_onehot);
    assign w_mover_map  = r_turn ? r_white : r_black;

    gobang_win_scan #(
        .BOARD_N (BOARD_N),
        .WIN_LEN (WIN_LEN)
    ) u_scan (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_start  (w_scan_start),
        .i_clear  (w_scan_clear),
        .i_row    (r_place_row),
        .i_col    (r_place_col),
        .i_bitmap (w_mover_map),
        .o_done   (w_scan_done),
        .o_win    (w_scan_win)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_black_nx     = r_black;
        w_white_nx     = r_white;
        w_row_nx       = r_row;
        w_col_nx       = r_col;
        w_place_row_nx = r_place_row;
        w_place_col_nx = r_place_col;
        w_turn_nx      = r_turn;
        w_winner_nx    = r_winner;
        w_count_nx     = r_count;
        w_scan_start   = 1'b0;
        w_scan_clear   = 1'b0;

        if (key_switch) begin
            w_state_nx     = PLAY;
            w_black_nx     = '0;
            w_white_nx     = '0;
            w_row_nx       = CENTER;
            w_col_nx       = CENTER;
            w_place_row_nx = '0;
            w_place_col_nx = '0;
            w_turn_nx      = 1'b0;
            w_winner_nx    = WIN_NONE;
            w_count_nx     = '0;
            w_scan_clear   = 1'b1;
        end else begin
            case (r_state)
                PLAY: begin
                    // An ok on an occupied cell still swallows the cursor keys.
                    if (key_ok) begin
                        if (!w_occupied) begin
                            if (r_turn) w_white_nx = r_white | w_cur_onehot;
                            else        w_black_nx = r_black | w_cur_onehot;
                            w_count_nx     = r_count + 1'b1;
                            w_place_row_nx = r_row;
                            w_place_col_nx = r_col;
                            w_scan_start   = 1'b1;
                            w_state_nx     = CHECK;
                        end
                    end else if (key_up) begin
                        w_row_nx = cur_dec(r_row);
                    end else if (key_down) begin
                        w_row_nx = cur_inc(r_row);
                    end else if (key_left) begin
                        w_col_nx = cur_dec(r_col);
                    end else if (key_right) begin
                        w_col_nx = cur_inc(r_col);
                    end
                end
                CHECK: begin
                    if (w_scan_done) begin
                        if (w_scan_win) begin
                            w_state_nx  = OVER;
                            w_winner_nx = r_turn ? WIN_WHITE : WIN_BLACK;
                        end else if (r_count == FULL) begin
                            w_state_nx  = OVER;
                            w_winner_nx = WIN_DRAW;
                        end else begin
                            w_turn_nx  = ~r_turn;
                            w_state_nx = PLAY;
                        end
                    end
                end
                OVER: begin
                end
                default: begin
                    w_state_nx = PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= PLAY;
            r_black     <= '0;
            r_white     <= '0;
            r_row       <= CENTER;
            r_col       <= CENTER;
            r_place_row <= '0;
            r_place_col <= '0;
            r_turn      <= 1'b0;
            r_busy      <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_black     <= w_black_nx;
            r_white     <= w_white_nx;
            r_row       <= w_row_nx;
            r_col       <= w_col_nx;
            r_place_row <= w_place_row_nx;
            r_place_col <= w_place_col_nx;
            r_turn      <= w_turn_nx;
            r_busy      <= (w_state_nx == CHECK);
            r_game_over <= (w_state_nx == OVER);
            r_winner    <= w_winner_nx;
            r_count     <= w_count_nx;
        end
    end

    assign display_black = r_black;
    assign display_white = r_white;
    assign choose_row    = r_row;
    assign choose_col    = r_col;
    assign turn          = r_turn;
    assign busy          = r_busy;
    assign game_over     = r_game_over;
    assign winner        = r_winner;
    assign move_count    = r_count;

endmodule

// File: tb/tb_gobang_game_ctrl.sv
// Bench for gobang_game_ctrl: three configurations (15x15 saturate,
// 15x15 wrap, 3x3 win-4) checked every cycle against a board-level model.
module tb_gobang_game_ctrl;

    localparam logic [5:0] M_UP = 6'b000001;
    localparam logic [5:0] M_DN = 6'b000010;
    localparam logic [5:0] M_LT = 6'b000100;
    localparam logic [5:0] M_RT = 6'b001000;
    localparam logic [5:0] M_OK = 6'b010000;
    localparam logic [5:0] M_SW = 6'b100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [5:0] keys [3];
    logic       cmp_en;
    int         checks   = 0;
    int         failures = 0;

    logic [224:0] a_blk, a_wht, b_blk, b_wht;
    logic [8:0]   c_blk, c_wht;
    logic [3:0]   a_row, a_col, b_row, b_col;
    logic [1:0]   c_row, c_col;
    logic         a_turn, b_turn, c_turn, a_busy, b_busy, c_busy;
    logic         a_over, b_over, c_over;
    logic [1:0]   a_win, b_win, c_win;
    logic [7:0]   a_cnt, b_cnt;
    logic [3:0]   c_cnt;

    gobang_game_ctrl #(.BOARD_N(15), .WIN_LEN(5), .CUR_WRAP(0)) dut_a (
        .clk(clk), .rst(rst),
        .key_up(keys[0][0]), .key_down(keys[0][1]), .key_left(keys[0][2]),
        .key_right(keys[0][3]), .key_ok(keys[0][4]), .key_switch(keys[0][5]),
        .display_black(a_blk), .display_white(a_wht), .choose_row(a_row),
        .choose_col(a_col), .turn(a_turn), .busy(a_busy), .game_over(a_over),
        .winner(a_win), .move_count(a_cnt));

    gobang_game_ctrl #(.BOARD_N(15), .WIN_LEN(5), .CUR_WRAP(1)) dut_b (
        .clk(clk), .rst(rst),
        .key_up(keys[1][0]), .key_down(keys[1][1]), .key_left(keys[1][2]),
        .key_right(keys[1][3]), .key_ok(keys[1][4]), .key_switch(keys[1][5]),
        .display_black(b_blk), .display_white(b_wht), .choose_row(b_row),
        .choose_col(b_col), .turn(b_turn), .busy(b_busy), .game_over(b_over),
        .winner(b_win), .move_count(b_cnt));

    gobang_game_ctrl #(.BOARD_N(3), .WIN_LEN(4), .CUR_WRAP(0)) dut_c (
        .clk(clk), .rst(rst),
        .key_up(keys[2][0]), .key_down(keys[2][1]), .key_left(keys[2][2]),
        .key_right(keys[2][3]), .key_ok(keys[2][4]), .key_switch(keys[2][5]),
        .display_black(c_blk), .display_white(c_wht), .choose_row(c_row),
        .choose_col(c_col), .turn(c_turn), .busy(c_busy), .game_over(c_over),
        .winner(c_win), .move_count(c_cnt));

    logic [224:0] act_blk [3];
    logic [224:0] act_wht [3];
    logic [3:0]   act_row [3];
    logic [3:0]   act_col [3];
    logic [7:0]   act_cnt [3];
    logic [1:0]   act_win [3];
    logic         act_turn [3];
    logic         act_busy [3];
    logic         act_over [3];

    assign act_blk[0] = a_blk;          assign act_blk[1] = b_blk;
    assign act_blk[2] = 225'(c_blk);
    assign act_wht[0] = a_wht;          assign act_wht[1] = b_wht;
    assign act_wht[2] = 225'(c_wht);
    assign act_row[0] = a_row;          assign act_row[1] = b_row;
    assign act_row[2] = {2'b00, c_row};
    assign act_col[0] = a_col;          assign act_col[1] = b_col;
    assign act_col[2] = {2'b00, c_col};
    assign act_cnt[0] = a_cnt;          assign act_cnt[1] = b_cnt;
    assign act_cnt[2] = {4'd0, c_cnt};
    assign act_win[0] = a_win;  assign act_win[1] = b_win;  assign act_win[2] = c_win;
    assign act_turn[0] = a_turn; assign act_turn[1] = b_turn; assign act_turn[2] = c_turn;
    assign act_busy[0] = a_busy; assign act_busy[1] = b_busy; assign act_busy[2] = c_busy;
    assign act_over[0] = a_over; assign act_over[1] = b_over; assign act_over[2] = c_over;

    // ---------------- behavioural model ----------------
    int p_n [3]    = '{15, 15, 3};
    int p_w [3]    = '{5, 5, 4};
    int p_wrap [3] = '{0, 1, 0};

    int m_brd [3][15][15];
    int m_row [3], m_col [3], m_turn [3], m_phase [3];
    int m_timer [3], m_pend [3], m_winner [3], m_cnt [3];

    task automatic model_reset(input int k);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) m_brd[k][r][c] = 0;
        m_row[k] = p_n[k] / 2;  m_col[k] = p_n[k] / 2;
        m_turn[k] = 0;  m_phase[k] = 0;  m_timer[k] = 0;
        m_pend[k] = 0;  m_winner[k] = 0; m_cnt[k] = 0;
    endtask

    function automatic int has_win(input int k, input int r, input int c, input int colr);
        int drs [4];
        int dcs [4];
        drs = '{0, 1, 1, 1};
        dcs = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++) begin
            int len = 1;
            for (int s = -1; s <= 1; s += 2) begin
                for (int i = 1; i < p_w[k]; i++) begin
                    int rr = r + s * i * drs[d];
                    int cc = c + s * i * dcs[d];
                    if (rr < 0 || rr >= p_n[k] || cc < 0 || cc >= p_n[k]) break;
                    if (m_brd[k][rr][cc] != colr) break;
                    len++;
                end
            end
            if (len >= p_w[k]) return 1;
        end
        return 0;
    endfunction

    task automatic model_step(input int k, input logic [5:0] kk);
        int n = p_n[k];
        if (kk[5]) begin
            model_reset(k);
        end else if (m_phase[k] == 0) begin
            if (kk[4]) begin
                if (m_brd[k][m_row[k]][m_col[k]] == 0) begin
                    m_brd[k][m_row[k]][m_col[k]] = m_turn[k] + 1;
                    m_cnt[k]++;
                    m_phase[k] = 1;
                    m_timer[k] = 8 * (p_w[k] - 1);
                    m_pend[k]  = has_win(k, m_row[k], m_col[k], m_turn[k] + 1);
                end
            end else if (kk[0]) begin
                m_row[k] = (m_row[k] == 0) ? ((p_wrap[k] != 0) ? n - 1 : 0) : m_row[k] - 1;
            end else if (kk[1]) begin
                m_row[k] = (m_row[k] == n - 1) ? ((p_wrap[k] != 0) ? 0 : n - 1) : m_row[k] + 1;
            end else if (kk[2]) begin
                m_col[k] = (m_col[k] == 0) ? ((p_wrap[k] != 0) ? n - 1 : 0) : m_col[k] - 1;
            end else if (kk[3]) begin
                m_col[k] = (m_col[k] == n - 1) ? ((p_wrap[k] != 0) ? 0 : n - 1) : m_col[k] + 1;
            end
        end else if (m_phase[k] == 1) begin
            m_timer[k]--;
            if (m_timer[k] == 0) begin
                if (m_pend[k] != 0) begin
                    m_phase[k] = 2;  m_winner[k] = (m_turn[k] != 0) ? 2 : 1;
                end else if (m_cnt[k] == n * n) begin
                    m_phase[k] = 2;  m_winner[k] = 3;
                end else begin
                    m_turn[k] ^= 1;  m_phase[k] = 0;
                end
            end
        end
    endtask

    function automatic logic [224:0] model_map(input int k, input int colr);
        logic [224:0] m = '0;
        for (int r = 0; r < p_n[k]; r++)
            for (int c = 0; c < p_n[k]; c++)
                if (m_brd[k][r][c] == colr) m[r * p_n[k] + c] = 1'b1;
        return m;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) model_reset(k);
        end else begin
            for (int k = 0; k < 3; k++) model_step(k, keys[k]);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [224:0] act, input logic [224:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("k%0d_black", k), act_blk[k], model_map(k, 1));
                chk($sformatf("k%0d_white", k), act_wht[k], model_map(k, 2));
                chk($sformatf("k%0d_row", k), 225'(act_row[k]), 225'(m_row[k]));
                chk($sformatf("k%0d_col", k), 225'(act_col[k]), 225'(m_col[k]));
                chk($sformatf("k%0d_turn", k), 225'(act_turn[k]), 225'(m_turn[k]));
                chk($sformatf("k%0d_busy", k), 225'(act_busy[k]), 225'(m_phase[k] == 1));
                chk($sformatf("k%0d_over", k), 225'(act_over[k]), 225'(m_phase[k] == 2));
                chk($sformatf("k%0d_winner", k), 225'(act_win[k]), 225'(m_winner[k]));
                chk($sformatf("k%0d_count", k), 225'(act_cnt[k]), 225'(m_cnt[k]));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic press(input int k, input logic [5:0] m);
        keys[k] = m;
        @(negedge clk);
        keys[k] = 6'd0;
    endtask

    task automatic move_to(input int k, input int r, input int c);
        for (int i = 0; i < 64; i++) begin
            if (m_row[k] == r && m_col[k] == c) break;
            if (m_row[k] > r)      press(k, M_UP);
            else if (m_row[k] < r) press(k, M_DN);
            else if (m_col[k] > c) press(k, M_LT);
            else                   press(k, M_RT);
        end
    endtask

    task automatic wait_idle(input int k);
        int i = 0;
        while (act_busy[k] && i < 300) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (act_busy[k]) begin
            failures++;
            $display("FAIL k%0d_busy_timeout actual=busy required=idle within 300 cycles", k);
        end
    endtask

    task automatic place(input int k, input int r, input int c);
        move_to(k, r, c);
        press(k, M_OK);
        wait_idle(k);
    endtask

    function automatic logic [5:0] rand_mask();
        logic [5:0] m;
        m[0] = ($urandom_range(0, 3) == 0);
        m[1] = ($urandom_range(0, 3) == 0);
        m[2] = ($urandom_range(0, 3) == 0);
        m[3] = ($urandom_range(0, 3) == 0);
        m[4] = ($urandom_range(0, 5) == 0);
        m[5] = ($urandom_range(0, 399) == 0);
        return m;
    endfunction

    int hz_seq [18]  = '{3,0, 10,0, 3,1, 10,2, 3,2, 10,4, 3,3, 12,1, 3,4};
    int nw_seq [18]  = '{5,12, 0,0, 5,13, 0,2, 5,14, 0,4, 6,0, 0,6, 6,1};
    int dg_seq [20]  = '{2,0, 10,14, 2,2, 11,13, 2,4, 12,12, 2,6, 13,11, 2,8, 14,10};
    int dr_seq [18]  = '{0,0, 0,1, 0,2, 1,0, 1,1, 1,2, 2,0, 2,1, 2,2};

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst    = 1'b0;
        cmp_en = 1'b0;
        for (int k = 0; k < 3; k++) keys[k] = 6'd0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        chk("rst_row", 225'(a_row), 225'd7);
        chk("rst_col", 225'(a_col), 225'd7);
        chk("rst_c_row", 225'(c_row), 225'd1);
        chk("rst_blk", a_blk, '0);

        // First stone at the centre; scan lasts 8*(5-1) cycles.
        press(0, M_OK);
        chk("t1_bit112", 225'(a_blk[112]), 225'd1);
        chk("t1_busy_rise", 225'(a_busy), 225'd1);
        n = 0;
        while (a_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t1_busy_len", 225'(n), 225'd32);
        chk("t1_turn", 225'(a_turn), 225'd1);

        move_to(0, 0, 0);
        press(0, M_UP);
        press(0, M_LT);
        chk("sat_row", 225'(a_row), 225'd0);
        chk("sat_col", 225'(a_col), 225'd0);

        move_to(0, 7, 7);
        press(0, M_OK);
        chk("occ_busy", 225'(a_busy), 225'd0);
        chk("occ_turn", 225'(a_turn), 225'd1);
        chk("occ_cnt", 225'(a_cnt), 225'd1);
        chk("occ_blk", a_blk, 225'd1 << 112);

        move_to(1, 0, 0);
        press(1, M_UP);
        press(1, M_LT);
        chk("wrap_row", 225'(b_row), 225'd14);
        chk("wrap_col", 225'(b_col), 225'd14);
        press(1, M_UP | M_RT);
        chk("pri_row", 225'(b_row), 225'd13);
        chk("pri_col", 225'(b_col), 225'd14);

        press(0, M_SW);
        for (int i = 0; i < 9; i++) place(0, hz_seq[2*i], hz_seq[2*i+1]);
        chk("hz_winner", 225'(a_win), 225'd1);
        chk("hz_over", 225'(a_over), 225'd1);
        press(0, M_OK);
        press(0, M_DN);
        chk("hz_hold_row", 225'(a_row), 225'd3);
        chk("hz_hold_cnt", 225'(a_cnt), 225'd9);
        press(0, M_SW);
        chk("hz_sw_blk", a_blk, '0);
        chk("hz_sw_row", 225'(a_row), 225'd7);
        chk("hz_sw_winner", 225'(a_win), 225'd0);

        for (int i = 0; i < 9; i++) place(0, nw_seq[2*i], nw_seq[2*i+1]);
        chk("nw_over", 225'(a_over), 225'd0);
        chk("nw_turn", 225'(a_turn), 225'd1);
        for (int i = 0; i < 10; i++) place(0, dg_seq[2*i], dg_seq[2*i+1]);
        chk("dg_winner", 225'(a_win), 225'd1);
        chk("dg_cnt", 225'(a_cnt), 225'd19);

        for (int i = 0; i < 9; i++) place(2, dr_seq[2*i], dr_seq[2*i+1]);
        chk("dr_winner", 225'(c_win), 225'd3);
        chk("dr_cnt", 225'(c_cnt), 225'd9);

        press(2, M_SW);
        press(2, M_OK);
        chk("ab_busy_rise", 225'(c_busy), 225'd1);
        repeat (4) @(negedge clk);
        press(2, M_SW);
        chk("ab_busy", 225'(c_busy), 225'd0);
        chk("ab_blk", 225'(c_blk), '0);

        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
            for (int k = 0; k < 3; k++) keys[k] = rand_mask();
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) keys[k] = 6'd0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
